acumulador_saturador: RTL
=========================

Name: acumulador_saturador

Overview:
- Downstream consumer of the 2N-bit extended-sum words from the sign-extension/concatenation stage.
- Accumulates a packet of extended terms in a guarded 2N+G accumulator.
- Rounds and saturates the result back to the N-bit Q(1,10,14) format.
- Returns the result to the filter datapath over a valid/ready handshake.

Parameters:
- N, 25, width of the narrow word: sign + 10 integer + 14 fraction bits.
- G, 4, accumulator guard bits; max terms per packet = 2^G.
- MB, 10, integer magnitude bits in both formats.
- FA, 14, fraction bits of the narrow word.
- FB, 19, zero-pad LSBs of the extended word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- in_data  in  2N  extended term. Layout: sign copies [2N-1:MB+FA+FB], integer [MB+FA+FB-1:FA+FB], fraction [FA+FB-1:FB], zeros [FB-1:0].
- in_valid  in  1  in_data/in_last are valid.
- in_last  in  1  marks the final term of a packet.
- in_ready  out  1  block accepts a term this cycle.
- out_data  out  N  rounded, saturated Q(1,10,14) result.
- out_valid  out  1  out_data/out_sat are valid.
- out_ready  in  1  consumer accepts the result.
- out_sat  out  1  result was clamped.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, out_sat=0, in_ready=1 once reset deasserts.
- Reset mid-packet or mid-output discards everything; no partial result is emitted.
- Transfer: occurs when in_valid && in_ready. Terms are sign-extended by G bits before use.
- in_ready=1 only in IDLE and ACUM. out_valid=1 only in SALIDA.
- IDLE: on transfer, acc<=sext(in_data), cnt<=1.
  - If in_last, go to CONV; otherwise go to ACUM.
- ACUM: on transfer, acc<=acc+sext(in_data), cnt<=cnt+1.
  - If in_last or cnt==2^G-1, go to CONV. The 2^G-th term force-closes the packet.
  - No transfer: hold.
- CONV (one cycle, no input accepted): out_data/out_sat registered from acc, then go to SALIDA.
- SALIDA: hold out_data, out_valid, out_sat stable until out_ready=1.
  - On the out_ready cycle, go to IDLE and clear out_valid.
  - No bypass: a new packet starts at the earliest on the cycle after the handshake.
- Latency: last term accepted at edge k → out_valid=1 after edge k+1. Throughput is one packet per (terms+2) cycles with out_ready held high.
- Conversion:
  - r = acc + 2^(FB-1) when rounding is enabled (see Optional Feature), else r = acc.
  - If r[2N+G-1:MB+FA+FB] are all equal: out_data=r[MB+FA+FB:FB], out_sat=0.
  - Else clamp: r positive → 0x0FFFFFF; r negative → 0x1000000; out_sat=1.
- Accumulator arithmetic: two's complement, 2N+G bits, wraps only beyond 2^G full-scale terms, which the forced close prevents.

Optional Feature:
- Macro: REDONDEO_EN.
- Defined: round half-up at bit FB-1 before saturation. The rounding add is included in the saturation check.
- Undefined: truncation (floor toward −∞), no adder in CONV.

Decomposition:
- Shared package holds:
  - N, G, MA=5, MB, FA, FB constants.
  - State encoding IDLE/ACUM/CONV/SALIDA.
  - Saturation constants SAT_POS=0x0FFFFFF, SAT_NEG=0x1000000.
- One combinational sub-module, redondeo_saturacion: takes acc, produces out_data and out_sat. It contains the REDONDEO_EN logic.
- The FSM, counter and accumulator stay in the top block.

Test Plan:
- Three terms 1.0, 2.0, −0.5 (narrow 0x004000, 0x008000, 0x1FFE000, extended <<FB), last on the third → out_data=0x00A000, out_sat=0, out_valid exactly one cycle after the last transfer.
- Ten terms of +600.0 (0x0960000) → out_data=0x0FFFFFF, out_sat=1. Ten terms of −600.0 → out_data=0x1000000, out_sat=1.
- Single term 2^(FB-1), last=1 → out_data=0x0000001 with REDONDEO_EN, 0x0000000 without. Term −2^(FB-1) → 0x0000000 with, 0x1FFFFFF without.
- 20 terms of 0.25 with no in_last → packet closes after 16 (out_data=0x010000); remaining 4 form a new packet giving 0x004000.
- Hold out_ready=0 for 5 cycles in SALIDA with in_valid=1 → in_ready=0, out_data stable, no term lost. On release, the pending term becomes the first term of the next packet.
- Assert reset during ACUM after 2 terms → all outputs 0, no out_valid. The next packet 1.0+1.0 gives 0x008000.

Source files
------------

// File: rtl/acumulador_saturador_pkg.sv
// Shared constants, state encoding and helpers for the packet accumulator.
// Rounding behaviour is selected by the REDONDEO_EN macro in the conversion stage.
package acumulador_saturador_pkg;

    localparam int unsigned N  = 25;
    localparam int unsigned G  = 4;
    localparam int unsigned MA = 5;
    localparam int unsigned MB = 10;
    localparam int unsigned FA = 14;
    localparam int unsigned FB = 19;

    localparam int unsigned W2        = 2 * N;
    localparam int unsigned AW        = 2 * N + G;
    localparam int unsigned CW        = G + 1;
    localparam int unsigned MSB       = MB + FA + FB;
    localparam int unsigned MAX_TERMS = 1 << G;

    localparam logic [N-1:0]  SAT_POS = N'(25'h0FFFFFF);
    localparam logic [N-1:0]  SAT_NEG = N'(25'h1000000);
    localparam logic [AW-1:0] RND_INC = AW'(64'd1 << (FB - 1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACUM   = 2'd1,
        CONV   = 2'd2,
        SALIDA = 2'd3
    } estado_t;

    // Widen an extended term by the guard bits, preserving its sign.
    function automatic logic [AW-1:0] sext(input logic [W2-1:0] x);
        return {{G{x[W2-1]}}, x};
    endfunction

endpackage

// File: rtl/acumulador_saturador_redondeo_saturacion.sv
// Converts the guarded accumulator back to Q(1,10,14), clamping on overflow.
// REDONDEO_EN selects round half-up; otherwise the result is truncated toward -inf.
module redondeo_saturacion
    import acumulador_saturador_pkg::*;
(
    input  logic [AW-1:0] acc,
    output logic [N-1:0]  out_data_c,
    output logic          out_sat_c
);

    logic [AW-1:0]     r;
    logic [AW-MSB-1:0] hi;
    logic              fits;
    logic              unused_lsb;

`ifdef REDONDEO_EN
    assign r = acc + RND_INC;
`else
    assign r = acc;
`endif

    // The value fits the narrow format when every bit above the integer field copies the sign.
    assign hi         = r[AW-1:MSB];
    assign fits       = (&hi) | ~(|hi);
    assign unused_lsb = ^r[FB-1:0];

    always_comb begin
        out_data_c = r[MSB:FB];
        out_sat_c  = 1'b0;
        if (!fits) begin
            out_sat_c  = 1'b1;
            out_data_c = r[AW-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/acumulador_saturador.sv
// Accumulates packets of extended terms and returns a rounded, saturated narrow result.
// Build option: REDONDEO_EN enables round half-up in the conversion stage.
module acumulador_saturador
    import acumulador_saturador_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [W2-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sat
);

    estado_t       estado, estado_d;
    logic [AW-1:0] acc, acc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [N-1:0]  out_data_d;
    logic          out_valid_d;
    logic          out_sat_d;
    logic          in_ready_d;
    logic          xfer;
    logic [N-1:0]  conv_data;
    logic          conv_sat;

    redondeo_saturacion u_rs (
        .acc        (acc),
        .out_data_c (conv_data),
        .out_sat_c  (conv_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            estado    <= estado_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_sat   <= out_sat_d;
            in_ready  <= in_ready_d;
        end
    end

    always_comb begin
        estado_d    = estado;
        acc_d       = acc;
        cnt_d       = cnt;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_sat_d   = out_sat;
        xfer        = in_valid && in_ready;

        case (estado)
            IDLE: begin
                if (xfer) begin
                    acc_d    = sext(in_data);
                    cnt_d    = CW'(1);
                    estado_d = in_last ? CONV : ACUM;
                end
            end
            ACUM: begin
                // The 2^G-th term closes the packet so the guard bits can never overflow.
                if (xfer) begin
                    acc_d = acc + sext(in_data);
                    cnt_d = cnt + CW'(1);
                    if (in_last || (cnt == CW'(MAX_TERMS - 1))) begin
                        estado_d = CONV;
                    end
                end
            end
            CONV: begin
                out_data_d  = conv_data;
                out_sat_d   = conv_sat;
                out_valid_d = 1'b1;
                estado_d    = SALIDA;
            end
            SALIDA: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    estado_d    = IDLE;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        in_ready_d = (estado_d == IDLE) || (estado_d == ACUM);
    end

endmodule
